// File: rtl/barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and op classification helpers.
// Optional carry output is enabled by defining BSHIFT_CARRY_EN.
package barrel_shifter_pkg;

  typedef enum logic [2:0] {
    SHIFT_ROL = 3'd0,
    SHIFT_ROR = 3'd1,
    SHIFT_SLL = 3'd2,
    SHIFT_SRL = 3'd3,
    SHIFT_SRA = 3'd4
  } shift_op_e;

  // Codes above SRA pass data through untouched
  function automatic logic is_reserved(input shift_op_e op);
    return (op > SHIFT_SRA);
  endfunction

  function automatic logic is_left(input shift_op_e op);
    return (op == SHIFT_ROL) || (op == SHIFT_SLL);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage: conditional shift by 2^K then register; 1 cycle; holds when adv=0.
// Carry tracking (BSHIFT_CARRY_EN) records the last bit pushed out by the highest stage that shifted.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int N     = 8,
  parameter int TAG_W = 4,
  parameter int K     = 0,
  localparam int S    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [N-1:0]     prev_dat,
  input  logic [S-1:0]     prev_amt,
  input  shift_op_e        prev_op,
  input  logic [TAG_W-1:0] prev_tag,
`ifdef BSHIFT_CARRY_EN
  input  logic             prev_carry,
  output logic             stg_carry,
`endif
  output logic             stg_vld,
  output logic [N-1:0]     stg_dat,
  output logic [S-1:0]     stg_amt,
  output shift_op_e        stg_op,
  output logic [TAG_W-1:0] stg_tag
);

  localparam int SH = 1 << K;

  logic [N-1:0] shf_dat;

  always_comb begin
    shf_dat = prev_dat;
    if (prev_amt[K] && !is_reserved(prev_op)) begin
      case (prev_op)
        SHIFT_ROL: shf_dat = {prev_dat[N-SH-1:0], prev_dat[N-1:N-SH]};
        SHIFT_ROR: shf_dat = {prev_dat[SH-1:0], prev_dat[N-1:SH]};
        SHIFT_SLL: shf_dat = {prev_dat[N-SH-1:0], {SH{1'b0}}};
        SHIFT_SRL: shf_dat = {{SH{1'b0}}, prev_dat[N-1:SH]};
        SHIFT_SRA: shf_dat = {{SH{prev_dat[N-1]}}, prev_dat[N-1:SH]};
        default:   shf_dat = prev_dat;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld <= 1'b0;
      stg_dat <= '0;
      stg_amt <= '0;
      stg_op  <= SHIFT_ROL;
      stg_tag <= '0;
    end else if (adv) begin
      stg_vld <= prev_vld;
      stg_dat <= shf_dat;
      stg_amt <= prev_amt;
      stg_op  <= prev_op;
      stg_tag <= prev_tag;
    end
  end

`ifdef BSHIFT_CARRY_EN
  logic shf_carry;

  // Later (larger) stages overwrite the carry, so the final value is the last bit out overall
  always_comb begin
    shf_carry = prev_carry;
    if (prev_amt[K] && !is_reserved(prev_op)) begin
      shf_carry = is_left(prev_op) ? prev_dat[N-SH] : prev_dat[SH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_carry <= 1'b0;
    end else if (adv) begin
      stg_carry <= shf_carry;
    end
  end
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined rotate/shift unit, S=log2(N) stages; result S cycles after accept, one per cycle.
// Backpressure: whole pipe advances only when output is empty or taken; in_ready mirrors that. Carry via BSHIFT_CARRY_EN.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int N     = 8,
  parameter int TAG_W = 4,
  localparam int S    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [S-1:0]     in_amt,
  input  shift_op_e        in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
`ifdef BSHIFT_CARRY_EN
  output logic             out_carry,
`endif
  output logic [TAG_W-1:0] out_tag
);

  logic             adv;
  logic             vld_p [0:S];
  logic [N-1:0]     dat_p [0:S];
  logic [S-1:0]     amt_p [0:S];
  shift_op_e        op_p  [0:S];
  logic [TAG_W-1:0] tag_p [0:S];
`ifdef BSHIFT_CARRY_EN
  logic             carry_p [0:S];
`endif

  // Single global enable: no per-stage bubble collapsing, so capacity is exactly S
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign vld_p[0] = in_valid;
  assign dat_p[0] = in_data;
  assign amt_p[0] = in_amt;
  assign op_p[0]  = in_op;
  assign tag_p[0] = in_tag;
`ifdef BSHIFT_CARRY_EN
  assign carry_p[0] = 1'b0;
`endif

  for (genvar k = 0; k < S; k++) begin : g_stage
    barrel_shift_stage #(
      .N     (N),
      .TAG_W (TAG_W),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv),
      .prev_vld   (vld_p[k]),
      .prev_dat   (dat_p[k]),
      .prev_amt   (amt_p[k]),
      .prev_op    (op_p[k]),
      .prev_tag   (tag_p[k]),
`ifdef BSHIFT_CARRY_EN
      .prev_carry (carry_p[k]),
      .stg_carry  (carry_p[k+1]),
`endif
      .stg_vld    (vld_p[k+1]),
      .stg_dat    (dat_p[k+1]),
      .stg_amt    (amt_p[k+1]),
      .stg_op     (op_p[k+1]),
      .stg_tag    (tag_p[k+1])
    );
  end

  assign out_valid = vld_p[S];
  assign out_data  = dat_p[S];
  assign out_tag   = tag_p[S];
`ifdef BSHIFT_CARRY_EN
  assign out_carry = carry_p[S];
`endif

  // Amount and op are fully consumed by the last stage
  logic unused_tail;
  assign unused_tail = ^{amt_p[S], op_p[S]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (N=8, TAG_W=4); carry is compared when BSHIFT_CARRY_EN is defined.
module tb_barrel_shifter_pipe;
  import barrel_shifter_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [2:0]       in_amt;
  shift_op_e        in_op;
  logic [3:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [3:0]       out_tag;
`ifdef BSHIFT_CARRY_EN
  logic             out_carry;
`endif

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.N(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BSHIFT_CARRY_EN
    .out_carry (out_carry),
`endif
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] tag;
    logic       carry;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [2:0] op;
    logic [7:0] r;
    logic       c;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference computed directly from whole-amount shifts
  function automatic exp_t model(input logic [7:0] d, input logic [2:0] a,
                                 input logic [2:0] op, input logic [3:0] t);
    exp_t r;
    r.data  = d;
    r.tag   = t;
    r.carry = 1'b0;
    if (a != 3'd0) begin
      case (op)
        3'd0: begin r.data = (d << a) | (d >> (4'd8 - a)); r.carry = d[4'd8 - a]; end
        3'd1: begin r.data = (d >> a) | (d << (4'd8 - a)); r.carry = d[a - 3'd1]; end
        3'd2: begin r.data = d << a;                     r.carry = d[4'd8 - a]; end
        3'd3: begin r.data = d >> a;                     r.carry = d[a - 3'd1]; end
        3'd4: begin r.data = 8'($signed(d) >>> a);        r.carry = d[a - 3'd1]; end
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amt = '0; in_op = SHIFT_ROL; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef BSHIFT_CARRY_EN
    n_checks++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_out_carry: got %b want 0", out_carry); end
`endif
  endtask

  task automatic test_vectors();
    vec_t vt[8];
    exp_t e;
    int   idx, cyc, lat;
    // Latency of a single ROL operand
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_op = SHIFT_ROL; in_tag = 4'd3; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (out_valid === 1'b1) break;
    end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rol_latency: got %0d cycles want 3", lat); end
    n_checks++; if (out_data !== 8'h03 || out_tag !== 4'd3) begin
      n_fail++; $display("FAIL rol_result: got data %h tag %0d want 03 tag 3", out_data, out_tag);
    end
`ifdef BSHIFT_CARRY_EN
    n_checks++; if (out_carry !== 1'b1) begin n_fail++; $display("FAIL rol_carry: got %b want 1", out_carry); end
`endif
    vt = '{'{8'h90, 3'd3, 3'd4, 8'hF2, 1'b0},
           '{8'hFF, 3'd7, 3'd2, 8'h80, 1'b1},
           '{8'h01, 3'd1, 3'd1, 8'h80, 1'b1},
           '{8'h5A, 3'd2, 3'd6, 8'h5A, 1'b0},
           '{8'hA5, 3'd4, 3'd3, 8'h0A, 1'b0},
           '{8'h81, 3'd0, 3'd0, 8'h81, 1'b0},
           '{8'h3C, 3'd0, 3'd4, 8'h3C, 1'b0},
           '{8'hC3, 3'd4, 3'd0, 8'h3C, 1'b0}};
    idx = 0; cyc = 0;
    while ((idx < 8 || sb.size() > 0) && cyc < 100) begin
      @(negedge clk); cyc++;
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_data = vt[idx].d; in_amt = vt[idx].a; in_op = shift_op_e'(vt[idx].op); in_tag = 4'(idx);
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL vec_extra: unexpected result data %h tag %0d", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag
`ifdef BSHIFT_CARRY_EN
              || out_carry !== e.carry
`endif
             ) begin
            n_fail++; $display("FAIL vec_result: got data %h tag %0d want data %h tag %0d carry %b",
                               out_data, out_tag, e.data, e.tag, e.carry);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{vt[idx].r, 4'(idx), vt[idx].c});
        idx++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (cyc >= 100) begin n_fail++; $display("FAIL vec_timeout: %0d pending, want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_stall();
    exp_t       e;
    int         acc, got;
    logic [7:0] hold_dat;
    logic [3:0] hold_tag;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
    acc = 0; hold_dat = '0; hold_tag = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h13 * (t + 1)); in_amt = 3'(t); in_op = SHIFT_SLL; in_tag = 4'(t);
      #1;
      if (t == 3) begin hold_dat = out_data; hold_tag = out_tag; end
      if (t > 3) begin
        n_checks++;
        if (out_data !== hold_dat || out_tag !== hold_tag || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_stable: got data %h tag %0d vld %b want data %h tag %0d vld 1",
                             out_data, out_tag, out_valid, hold_dat, hold_tag);
        end
      end
      if (in_ready) begin
        acc++;
        sb.push_back(model(in_data, in_amt, 3'(in_op), in_tag));
      end
    end
    n_checks++; if (acc != 3) begin n_fail++; $display("FAIL stall_accepted: got %0d want 3", acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    got = 0;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: unexpected result tag %0d", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag
`ifdef BSHIFT_CARRY_EN
              || out_carry !== e.carry
`endif
             ) begin
            n_fail++; $display("FAIL stall_result: got data %h tag %0d want data %h tag %0d carry %b",
                               out_data, out_tag, e.data, e.tag, e.carry);
          end
        end
      end
    end
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL stall_delivered: got %0d want 3", got); end
    sb.delete();
  endtask

  task automatic test_midreset();
    int emitted;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h40 + i); in_amt = 3'd2; in_op = SHIFT_ROR; in_tag = 4'(i + 8);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_data !== 8'h00 || out_tag !== 4'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got data %h tag %0d want 00 tag 0", out_data, out_tag);
    end
    emitted = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) emitted++;
    end
    n_checks++; if (emitted != 0) begin n_fail++; $display("FAIL midreset_emitted: got %0d want 0", emitted); end
  endtask

  task automatic test_random();
    exp_t e;
    int   sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || sb.size() > 0) && cyc < 20000) begin
      @(negedge clk); cyc++;
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      in_op     = shift_op_e'(3'($urandom));
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: unexpected result data %h tag %0d", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag
`ifdef BSHIFT_CARRY_EN
              || out_carry !== e.carry
`endif
             ) begin
            n_fail++; $display("FAIL rand_result %0d: got data %h tag %0d want data %h tag %0d carry %b",
                               got, out_data, out_tag, e.data, e.tag, e.carry);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, in_amt, 3'(in_op), in_tag));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 1000) begin n_fail++; $display("FAIL rand_count: got %0d results want 1000", got); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
